// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stages: state encoding and the
// MEM->WB payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

  localparam int unsigned MEMWB_W       = 70;
  localparam int unsigned MEMWB_WEN_BIT = 0;
  localparam int unsigned MEMWB_RD_LSB  = 1;
  localparam int unsigned MEMWB_RD_W    = 5;
  localparam int unsigned MEMWB_PC_LSB  = 6;
  localparam int unsigned MEMWB_PC_W    = 64;

  typedef struct packed {
    logic [MEMWB_PC_W-1:0] pc;
    logic [MEMWB_RD_W-1:0] rd_waddr;
    logic                  reg_wen;
  } memwb_t;

  function automatic logic [MEMWB_W-1:0] memwb_pack(
    input logic [MEMWB_PC_W-1:0] pc,
    input logic [MEMWB_RD_W-1:0] rd_waddr,
    input logic                  reg_wen
  );
    return {pc, rd_waddr, reg_wen};
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush/NOP injection, optional
// two-entry skid buffer and a saturating back-pressure counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = MEMWB_W,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID_EN = 1'b1,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  ps_state_e         state;
  logic [DATA_W-1:0] main_q;
  logic              main_valid;
  logic              accept;
  logic              fire;

  assign accept      = in_valid_i & in_ready_o;
  assign fire        = main_valid & out_ready_i;
  assign out_valid_o = main_valid;
  assign out_data_o  = main_q;

  generate
    if (SKID_EN) begin : g_skid
      logic [DATA_W-1:0] skid_q;
      logic              skid_valid;
      logic              ready_q;

      // ready_q always equals !skid_valid; kept as its own flop so the
      // upstream ready is a clean register output.
      assign in_ready_o = ready_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state      <= PS_EMPTY;
          main_q     <= NOP_VAL;
          main_valid <= 1'b0;
          skid_q     <= NOP_VAL;
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
        end else if (flush_i) begin
          state      <= PS_EMPTY;
          main_q     <= NOP_VAL;
          main_valid <= 1'b0;
          skid_q     <= NOP_VAL;
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
        end else begin
          case (state)
            PS_EMPTY: begin
              if (accept) begin
                state      <= PS_BUSY;
                main_q     <= in_data_i;
                main_valid <= 1'b1;
              end
            end
            PS_BUSY: begin
              if (accept && fire) begin
                main_q <= in_data_i;
              end else if (accept) begin
                state      <= PS_FULL;
                skid_q     <= in_data_i;
                skid_valid <= 1'b1;
                ready_q    <= 1'b0;
              end else if (fire) begin
                state      <= PS_EMPTY;
                main_q     <= NOP_VAL;
                main_valid <= 1'b0;
              end
            end
            PS_FULL: begin
              if (fire) begin
                state      <= PS_BUSY;
                main_q     <= skid_q;
                skid_q     <= NOP_VAL;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
              end
            end
            default: begin
              state      <= PS_EMPTY;
              main_q     <= NOP_VAL;
              main_valid <= 1'b0;
              skid_q     <= NOP_VAL;
              skid_valid <= 1'b0;
              ready_q    <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_noskid
      assign in_ready_o = ~main_valid | out_ready_i;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state      <= PS_EMPTY;
          main_q     <= NOP_VAL;
          main_valid <= 1'b0;
        end else if (flush_i) begin
          state      <= PS_EMPTY;
          main_q     <= NOP_VAL;
          main_valid <= 1'b0;
        end else begin
          case (state)
            PS_EMPTY: begin
              if (accept) begin
                state      <= PS_BUSY;
                main_q     <= in_data_i;
                main_valid <= 1'b1;
              end
            end
            PS_BUSY: begin
              // In BUSY an accept implies a fire, so there is no hold-and-accept case.
              if (accept) begin
                main_q <= in_data_i;
              end else if (fire) begin
                state      <= PS_EMPTY;
                main_q     <= NOP_VAL;
                main_valid <= 1'b0;
              end
            end
            default: begin
              state      <= PS_EMPTY;
              main_q     <= NOP_VAL;
              main_valid <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

  sat_cnt #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (main_valid & ~out_ready_i),
    .clr (cnt_clr_i),
    .cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a skid instance (A) and a no-skid instance (B),
// each checked against a queue-based model of its flow-control rules.
module tb_pipe_stage_hs;

  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 4;
  localparam logic [DW-1:0] NOP = 16'hDEAD;
  localparam int unsigned CMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          a_flush, a_iv, a_ir, a_ov, a_or, a_clr;
  logic [DW-1:0] a_id, a_od;
  logic [CW-1:0] a_cnt;
  logic          b_flush, b_iv, b_ir, b_ov, b_or, b_clr;
  logic [DW-1:0] b_id, b_od;
  logic [CW-1:0] b_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Models: contents of the stage in delivery order, plus stall counts.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int unsigned   cnta = 0;
  int unsigned   cntb = 0;

  pipe_stage_hs #(.DATA_W(DW), .NOP_VAL(NOP), .SKID_EN(1'b1), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .in_valid_i(a_iv), .in_ready_o(a_ir),
    .in_data_i(a_id), .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od),
    .cnt_clr_i(a_clr), .stall_cnt_o(a_cnt)
  );

  pipe_stage_hs #(.DATA_W(DW), .NOP_VAL(NOP), .SKID_EN(1'b0), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .in_valid_i(b_iv), .in_ready_o(b_ir),
    .in_data_i(b_id), .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od),
    .cnt_clr_i(b_clr), .stall_cnt_o(b_cnt)
  );

  task automatic drive_a(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
    a_iv = iv; a_id = d; a_or = ordy; a_flush = fl; a_clr = clr;
  endtask

  task automatic drive_b(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
    b_iv = iv; b_id = d; b_or = ordy; b_flush = fl; b_clr = clr;
  endtask

  // Advance both models by one clock using the currently driven inputs,
  // then move to the next falling edge.
  task automatic tick();
    bit fa, aa, sa, fb, ab, sb;
    fa = (qa.size() != 0) && a_or;
    aa = a_iv && (qa.size() < 2);
    sa = (qa.size() != 0) && !a_or;
    fb = (qb.size() != 0) && b_or;
    ab = b_iv && ((qb.size() == 0) || b_or);
    sb = (qb.size() != 0) && !b_or;
    if (a_clr) cnta = 0; else if (sa && cnta < CMAX) cnta++;
    if (b_clr) cntb = 0; else if (sb && cntb < CMAX) cntb++;
    if (a_flush) qa.delete();
    else begin
      if (fa) void'(qa.pop_front());
      if (aa) qa.push_back(a_id);
    end
    if (b_flush) qb.delete();
    else begin
      if (fb) void'(qb.pop_front());
      if (ab) qb.push_back(b_id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_a(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    drive_b(1'b1, 16'h4321, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (a_ov !== 1'b0) begin tests_failed++; $display("FAIL reset a_valid: got %b exp 0", a_ov); end
    tests_run++; if (a_od !== NOP) begin tests_failed++; $display("FAIL reset a_data: got %h exp %h", a_od, NOP); end
    tests_run++; if (a_ir !== 1'b1) begin tests_failed++; $display("FAIL reset a_ready: got %b exp 1", a_ir); end
    tests_run++; if (a_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset a_cnt: got %0d exp 0", a_cnt); end
    tests_run++; if (b_ov !== 1'b0 || b_od !== NOP || b_ir !== 1'b1 || b_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL reset b_outputs: got v=%b d=%h r=%b c=%0d exp v=0 d=%h r=1 c=0", b_ov, b_od, b_ir, b_cnt, NOP);
    end
    rst = 1'b1;
    qa.delete(); qb.delete(); cnta = 0; cntb = 0;
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive_a(1'b1, 16'h00A5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (a_ov !== 1'b1 || a_od !== 16'h00A5) begin
      tests_failed++; $display("FAIL first_accept: got v=%b d=%h exp v=1 d=00a5", a_ov, a_od);
    end
    tick();
  endtask

  task automatic test_streaming();
    for (int unsigned i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        drive_a(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        drive_b(1'b1, DW'(i + 16'h100), 1'b1, 1'b0, 1'b0);
      end else begin
        drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      #1;
      tests_run++; if (a_ir !== 1'b1 || b_ir !== 1'b1) begin
        tests_failed++; $display("FAIL stream ready cyc%0d: got a=%b b=%b exp 1", i, a_ir, b_ir);
      end
      if (i > 1) begin
        tests_run++; if (a_ov !== 1'b1 || a_od !== DW'(i - 1)) begin
          tests_failed++; $display("FAIL stream a_out cyc%0d: got v=%b d=%h exp v=1 d=%h", i, a_ov, a_od, DW'(i - 1));
        end
        tests_run++; if (b_ov !== 1'b1 || b_od !== DW'(i - 1 + 16'h100)) begin
          tests_failed++; $display("FAIL stream b_out cyc%0d: got v=%b d=%h exp v=1 d=%h", i, b_ov, b_od, DW'(i - 1 + 16'h100));
        end
      end
      tick();
    end
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic          iv_t[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [DW-1:0] d_t[8]  = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3, 16'd0, 16'd0};
    logic          or_t[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [DW-1:0] got[$];
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    for (int unsigned c = 0; c < 8; c++) begin
      drive_a(iv_t[c], d_t[c], or_t[c], 1'b0, 1'b0);
      #1;
      if (a_ov && a_or) got.push_back(a_od);
      tests_run++; if (a_ir !== (qa.size() < 2) || a_ov !== (qa.size() != 0)) begin
        tests_failed++; $display("FAIL bp handshake cyc%0d: got r=%b v=%b exp r=%b v=%b", c, a_ir, a_ov, qa.size() < 2, qa.size() != 0);
      end
      tests_run++; if (a_cnt !== CW'(cnta)) begin
        tests_failed++; $display("FAIL bp stall_cnt cyc%0d: got %0d exp %0d", c, a_cnt, cnta);
      end
      if (c == 2) begin
        tests_run++; if (a_ir !== 1'b0 || a_od !== 16'd1) begin
          tests_failed++; $display("FAIL bp full: got r=%b d=%h exp r=0 d=0001", a_ir, a_od);
        end
      end
      if (c == 4) begin
        tests_run++; if (a_cnt !== 4'd3) begin
          tests_failed++; $display("FAIL bp stall3: got %0d exp 3", a_cnt);
        end
      end
      tick();
    end
    tests_run++; if (got.size() != 3 || got[0] !== 16'd1 || got[1] !== 16'd2 || got[2] !== 16'd3) begin
      tests_failed++; $display("FAIL bp order: got %0d items first=%h exp 1,2,3", got.size(), (got.size() != 0) ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_flush_full();
    drive_a(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0); tick();
    drive_a(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0); tick();
    drive_a(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0);
    #1;
    tests_run++; if (a_ir !== 1'b0) begin tests_failed++; $display("FAIL flush precond ready: got %b exp 0", a_ir); end
    tick();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (a_ov !== 1'b0 || a_od !== NOP || a_ir !== 1'b1) begin
      tests_failed++; $display("FAIL flush result: got v=%b d=%h r=%b exp v=0 d=%h r=1", a_ov, a_od, a_ir, NOP);
    end
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      #1;
      tests_run++; if (a_ov !== 1'b0 || a_od !== NOP) begin
        tests_failed++; $display("FAIL flush residue cyc%0d: got v=%b d=%h exp v=0 d=%h", c, a_ov, a_od, NOP);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b1); tick();
    drive_a(1'b1, 16'h005A, 1'b0, 1'b0, 1'b0); tick();
    for (int unsigned c = 0; c < 20; c++) begin
      drive_a(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      tests_run++; if (a_cnt !== CW'(cnta)) begin
        tests_failed++; $display("FAIL sat ramp cyc%0d: got %0d exp %0d", c, a_cnt, cnta);
      end
      tick();
    end
    #1;
    tests_run++; if (a_cnt !== 4'd15) begin tests_failed++; $display("FAIL sat max: got %0d exp 15", a_cnt); end
    drive_a(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    #1;
    tests_run++; if (a_cnt !== 4'd0) begin tests_failed++; $display("FAIL sat clear: got %0d exp 0", a_cnt); end
    tests_run++; if (a_ov !== 1'b1 || a_od !== 16'h005A) begin
      tests_failed++; $display("FAIL sat hold: got v=%b d=%h exp v=1 d=005a", a_ov, a_od);
    end
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_noskid();
    drive_b(1'b1, 16'h0031, 1'b0, 1'b0, 1'b0); tick();
    drive_b(1'b1, 16'h0032, 1'b0, 1'b0, 1'b0);
    #1;
    tests_run++; if (b_ir !== 1'b0 || b_ov !== 1'b1 || b_od !== 16'h0031) begin
      tests_failed++; $display("FAIL noskid stall: got r=%b v=%b d=%h exp r=0 v=1 d=0031", b_ir, b_ov, b_od);
    end
    tick();
    drive_b(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (b_ir !== 1'b1) begin tests_failed++; $display("FAIL noskid passthru ready: got %b exp 1", b_ir); end
    tick();
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (b_ov !== 1'b1 || b_od !== 16'h0033) begin
      tests_failed++; $display("FAIL noskid swap: got v=%b d=%h exp v=1 d=0033", b_ov, b_od);
    end
    tick();
  endtask

  task automatic test_random();
    for (int unsigned c = 0; c < 600; c++) begin
      drive_a(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 39) == 0));
      drive_b(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 39) == 0));
      #1;
      tests_run++; if (a_ov !== (qa.size() != 0) || a_od !== ((qa.size() != 0) ? qa[0] : NOP)) begin
        tests_failed++; $display("FAIL rand a_out cyc%0d: got v=%b d=%h exp v=%b d=%h", c, a_ov, a_od, qa.size() != 0, (qa.size() != 0) ? qa[0] : NOP);
      end
      tests_run++; if (a_ir !== (qa.size() < 2) || a_cnt !== CW'(cnta)) begin
        tests_failed++; $display("FAIL rand a_ctl cyc%0d: got r=%b c=%0d exp r=%b c=%0d", c, a_ir, a_cnt, qa.size() < 2, cnta);
      end
      tests_run++; if (b_ov !== (qb.size() != 0) || b_od !== ((qb.size() != 0) ? qb[0] : NOP)) begin
        tests_failed++; $display("FAIL rand b_out cyc%0d: got v=%b d=%h exp v=%b d=%h", c, b_ov, b_od, qb.size() != 0, (qb.size() != 0) ? qb[0] : NOP);
      end
      tests_run++; if (b_ir !== ((qb.size() == 0) || b_or) || b_cnt !== CW'(cntb)) begin
        tests_failed++; $display("FAIL rand b_ctl cyc%0d: got r=%b c=%0d exp r=%b c=%0d", c, b_ir, b_cnt, (qb.size() == 0) || b_or, cntb);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    drive_a(1'b1, 16'h00C1, 1'b0, 1'b0, 1'b0);
    drive_b(1'b1, 16'h00C2, 1'b0, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 16'h00C3, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    rst = 1'b0;
    #1;
    tests_run++; if (a_ov !== 1'b0 || a_od !== NOP || a_ir !== 1'b1 || a_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL midreset a: got v=%b d=%h r=%b c=%0d exp v=0 d=%h r=1 c=0", a_ov, a_od, a_ir, a_cnt, NOP);
    end
    tests_run++; if (b_ov !== 1'b0 || b_od !== NOP || b_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL midreset b: got v=%b d=%h c=%0d exp v=0 d=%h c=0", b_ov, b_od, b_cnt, NOP);
    end
    qa.delete(); qb.delete(); cnta = 0; cntb = 0;
    @(negedge clk);
    rst = 1'b1;
    drive_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_saturation();
    test_noskid();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
